// File: rtl/wb_pdm_rx_channel.sv
// rtl/wb_pdm_rx_channel.sv - PDM microphone receiver with Wishbone read port
// Optional overrun detection compiled in with PDM_RX_OVERRUN_EN.
module wb_pdm_rx_channel #(
    parameter int BIT_RESOLUTION = 8,
    parameter int CLK_DIV        = 4
) (
    input  logic                      wb_clk_i,
    input  logic                      wb_rst_ni,
    input  logic                      wb_stb_i,
    output logic                      wb_ack_o,
    output logic [BIT_RESOLUTION-1:0] wb_dat_o,
    output logic                      pdm_clk_o,
    input  logic                      pdm_dat_i,
    output logic                      pdm_valid_o,
    output logic                      pdm_overrun_o
);

    localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0]          DIV_LAST   = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0]          DIV_HALF   = DIV_W'(CLK_DIV / 2);
    localparam logic [BIT_RESOLUTION-1:0] BIT_LAST   = '1;
    localparam logic [BIT_RESOLUTION:0]   SAMPLE_MAX = {1'b0, {BIT_RESOLUTION{1'b1}}};

    logic [DIV_W-1:0]          div_cnt_q, div_cnt_d;
    logic [BIT_RESOLUTION-1:0] bit_cnt_q, bit_cnt_d;
    logic [BIT_RESOLUTION:0]   ones_cnt_q, ones_cnt_d;
    logic [BIT_RESOLUTION-1:0] sample_q, sample_d;
    logic [BIT_RESOLUTION-1:0] dat_q, dat_d;
    logic                      ack_q, ack_d;
    logic                      pdm_clk_q, pdm_clk_d;
    logic                      valid_q, valid_d;
    logic                      sample_evt;
    logic                      window_done;
    logic [BIT_RESOLUTION:0]   ones_sum;

    always_comb begin
        div_cnt_d   = (div_cnt_q == DIV_LAST) ? '0 : div_cnt_q + DIV_W'(1);
        pdm_clk_d   = (div_cnt_d >= DIV_HALF);
        sample_evt  = (div_cnt_q == DIV_LAST);
        window_done = sample_evt && (bit_cnt_q == BIT_LAST);
        ones_sum    = ones_cnt_q + {{BIT_RESOLUTION{1'b0}}, pdm_dat_i};

        bit_cnt_d  = bit_cnt_q;
        ones_cnt_d = ones_cnt_q;
        sample_d   = sample_q;
        if (sample_evt) begin
            bit_cnt_d = bit_cnt_q + BIT_RESOLUTION'(1);
            if (window_done) begin
                // A full window of ones counts 2^N, which does not fit the sample width.
                sample_d   = (ones_sum > SAMPLE_MAX) ? SAMPLE_MAX[BIT_RESOLUTION-1:0]
                                                     : ones_sum[BIT_RESOLUTION-1:0];
                ones_cnt_d = '0;
            end else begin
                ones_cnt_d = ones_sum;
            end
        end

        ack_d = wb_stb_i;
        dat_d = wb_stb_i ? sample_q : dat_q;

        // A completing window wins over a read in the same cycle.
        valid_d = valid_q;
        if (window_done) begin
            valid_d = 1'b1;
        end else if (wb_stb_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            div_cnt_q  <= '0;
            bit_cnt_q  <= '0;
            ones_cnt_q <= '0;
            sample_q   <= '0;
            dat_q      <= '0;
            ack_q      <= 1'b0;
            pdm_clk_q  <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            div_cnt_q  <= div_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            ones_cnt_q <= ones_cnt_d;
            sample_q   <= sample_d;
            dat_q      <= dat_d;
            ack_q      <= ack_d;
            pdm_clk_q  <= pdm_clk_d;
            valid_q    <= valid_d;
        end
    end

`ifdef PDM_RX_OVERRUN_EN
    logic overrun_q, overrun_d;

    always_comb begin
        overrun_d = overrun_q;
        if (window_done && valid_q && !wb_stb_i) begin
            overrun_d = 1'b1;
        end else if (wb_stb_i) begin
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            overrun_q <= 1'b0;
        end else begin
            overrun_q <= overrun_d;
        end
    end

    assign pdm_overrun_o = overrun_q;
`else
    assign pdm_overrun_o = 1'b0;
`endif

    assign wb_ack_o    = ack_q;
    assign wb_dat_o    = dat_q;
    assign pdm_clk_o   = pdm_clk_q;
    assign pdm_valid_o = valid_q;

endmodule

// File: tb/tb_wb_pdm_rx_channel.sv
// tb/tb_wb_pdm_rx_channel.sv - scoreboard bench for wb_pdm_rx_channel (BIT_RESOLUTION=4, CLK_DIV=4)
module tb_wb_pdm_rx_channel;

    localparam int BR      = 4;
    localparam int CD      = 4;
    localparam int WIN_CYC = (1 << BR) * CD;

    logic          wb_clk_i = 1'b0;
    logic          wb_rst_ni;
    logic          wb_stb_i;
    logic          wb_ack_o;
    logic [BR-1:0] wb_dat_o;
    logic          pdm_clk_o;
    logic          pdm_dat_i;
    logic          pdm_valid_o;
    logic          pdm_overrun_o;

    wb_pdm_rx_channel #(.BIT_RESOLUTION(BR), .CLK_DIV(CD)) dut (
        .wb_clk_i      (wb_clk_i),
        .wb_rst_ni     (wb_rst_ni),
        .wb_stb_i      (wb_stb_i),
        .wb_ack_o      (wb_ack_o),
        .wb_dat_o      (wb_dat_o),
        .pdm_clk_o     (pdm_clk_o),
        .pdm_dat_i     (pdm_dat_i),
        .pdm_valid_o   (pdm_valid_o),
        .pdm_overrun_o (pdm_overrun_o)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    int          n_chk  = 0;
    int          n_fail = 0;
    int          cyc    = 0;
    int          mode   = 0;
    logic [BR-1:0] sb_q[$];
    logic [BR-1:0] exp_sample = '0;
    logic [BR-1:0] exp_dat    = '0;
    logic          exp_valid  = 1'b0;
    logic          exp_ovr    = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // mode 0: all zeros, 1: all ones, 2: 1,0 alternating from the first event of a window
    function automatic logic drive_bit(input int e);
        int idx;
        if (e % CD != 0) return 1'($urandom_range(0, 1));
        idx = ((e / CD) - 1) % (1 << BR);
        case (mode)
            1:       return 1'b1;
            2:       return (idx % 2) == 0;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [BR-1:0] win_val(input int m);
        case (m)
            1:       return 4'd15;
            2:       return 4'd8;
            default: return 4'd0;
        endcase
    endfunction

    task automatic step(input logic stb);
        int   e;
        logic done;
        logic set_ovr;
        e = cyc + 1;
        wb_stb_i  = stb;
        pdm_dat_i = drive_bit(e);
        if (stb) sb_q.push_back(exp_sample);
        @(posedge wb_clk_i);
        #1;
        cyc     = e;
        done    = (e % WIN_CYC) == 0;
        set_ovr = done && exp_valid && !stb;
        if (done) begin
            exp_sample = win_val(mode);
            exp_valid  = 1'b1;
        end else if (stb) begin
            exp_valid = 1'b0;
        end
`ifdef PDM_RX_OVERRUN_EN
        if (set_ovr) exp_ovr = 1'b1;
        else if (stb) exp_ovr = 1'b0;
`else
        exp_ovr = 1'b0;
`endif
        chk("ack", wb_ack_o, stb);
        if (stb && sb_q.size() > 0) exp_dat = sb_q.pop_front();
        chk("dat", wb_dat_o, exp_dat);
        chk("pdm_clk", pdm_clk_o, (e % CD) >= (CD / 2));
        chk("valid", pdm_valid_o, exp_valid);
        chk("overrun", pdm_overrun_o, exp_ovr);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1'b0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ack"},     wb_ack_o, 0);
        chk({tag, "_dat"},     wb_dat_o, 0);
        chk({tag, "_pdm_clk"}, pdm_clk_o, 0);
        chk({tag, "_valid"},   pdm_valid_o, 0);
        chk({tag, "_overrun"}, pdm_overrun_o, 0);
    endtask

    task automatic release_reset();
        wb_rst_ni  = 1'b1;
        cyc        = 0;
        exp_sample = '0;
        exp_dat    = '0;
        exp_valid  = 1'b0;
        exp_ovr    = 1'b0;
        sb_q.delete();
    endtask

    initial begin
        wb_rst_ni = 1'b0;
        wb_stb_i  = 1'b0;
        pdm_dat_i = 1'b0;
        repeat (3) @(posedge wb_clk_i);
        #1;
        chk_all_zero("reset");
        release_reset();

        // Window 1: all ones saturates to 15
        mode = 1;
        run(WIN_CYC);
        chk("win1_sample_valid", pdm_valid_o, 1);
        // Window 2: alternating -> 8; read of window 1 in its first cycle
        mode = 2;
        step(1'b1);
        run(WIN_CYC - 1);
        // Window 3: zeros -> 0
        mode = 0;
        step(1'b1);
        run(WIN_CYC - 1);
        // Window 4: ones with no read of window 3 -> overwrite
        mode = 1;
        run(WIN_CYC);
        // Window 5: read returns the second sample and clears flags; strobe on completion
        mode = 2;
        step(1'b1);
        run(WIN_CYC - 2);
        step(1'b1);
        chk("same_cycle_valid", pdm_valid_o, 1);
        step(1'b1);
        run(21);

        // Reset mid-window with a strobe pending
        wb_stb_i = 1'b1;
        #2;
        wb_rst_ni = 1'b0;
        #1;
        chk_all_zero("async_reset");
        @(posedge wb_clk_i);
        #1;
        chk_all_zero("reset_held");
        wb_stb_i = 1'b0;
        release_reset();

        // Full window of ones after reset: nothing from the partial window leaks in
        mode = 1;
        run(WIN_CYC - 1);
        chk("post_reset_not_yet", pdm_valid_o, 0);
        step(1'b0);
        chk("post_reset_done", pdm_valid_o, 1);
        step(1'b1);
        run(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
